serial_port: RTL and testbench
==============================

# serial_port

Memory-side counterpart of the processor's serial interface: it accepts bytes the processor writes, serialises them onto a UART TX line, and deserialises the UART RX line into bytes the processor reads. The processor's write port (`serial_out`, `serial_wren_out`) drives this block's write side, and this block drives the processor's `serial_in`, `serial_valid_in` and `serial_ready_in`. Each direction is buffered by a small first-word-fall-through FIFO.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200 baud); integer ≥ 4.
- `FIFO_DEPTH`, default 8: entries in each of the TX and RX FIFOs; power of two, ≥ 2.

- `clock` in 1: the single clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `wr_data_in` in 8: byte from the processor (its `serial_out`).
- `wren_in` in 1: write strobe, one byte per cycle.
- `rden_in` in 1: pop strobe for the head of the RX FIFO.
- `rd_data_out` out 8: RX FIFO head, to processor `serial_in`.
- `valid_out` out 1: RX FIFO non-empty, to processor `serial_valid_in`.
- `ready_out` out 1: TX FIFO not full, to processor `serial_ready_in`.
- `tx_out` out 1: UART transmit line, idle high.
- `rx_in` in 1: UART receive line, asynchronous to `clock`.
- `rx_error_out` out 1: sticky error flag for overrun, framing or parity errors. It is cleared only by reset.

## Operation
- **Frame format:** 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- **Write side:**
  - `wren_in` with `ready_out`=1 pushes `wr_data_in`.
  - `wren_in` with `ready_out`=0 is ignored and the byte is dropped. No error is flagged.
- **Read side:**
  - `rd_data_out` is the FIFO head and is valid whenever `valid_out`=1.
  - `rden_in` with `valid_out`=1 pops the head.
  - `rden_in` with `valid_out`=0 is ignored.
  - When empty, `rd_data_out` holds its last value.
- **TX FSM** states: IDLE → START → DATA (8 bits) → [PARITY] → STOP → IDLE.
  - In IDLE with the TX FIFO non-empty, it pops the head into the shift register and enters START.
  - At the end of STOP with the FIFO non-empty, it pops and goes directly to START (back-to-back frames, no idle gap).
  - `tx_out` is 1 in IDLE and STOP.
- **RX path:** `rx_in` passes through a 2-flop synchroniser.
- **RX FSM** states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a synchronised 1→0 transition enters START.
  - START: re-samples at `CLKS_PER_BIT/2`. If the line is high (false start), it returns to IDLE with no error. If low, it proceeds.
  - DATA, PARITY and STOP bits are each sampled every `CLKS_PER_BIT` cycles after that mid-start point.
  - STOP sampled 1 and parity OK: push the byte to the RX FIFO.
  - STOP sampled 0: framing error. The byte is dropped, `rx_error_out` is set, and the FSM returns to IDLE; the next falling edge restarts it.
  - Push when RX FIFO full and no simultaneous pop: overrun. The new byte is dropped and `rx_error_out` is set.
  - Simultaneous push and pop on a full RX FIFO: both take effect and no overrun is flagged.
  - Simultaneous push and pop on the TX FIFO are also legal at any occupancy.
- **Bit timer:** counts 0..`CLKS_PER_BIT-1` and wraps. Its width is `$clog2(CLKS_PER_BIT)`.

## Timing
- **Reset values:** `tx_out`=1, `ready_out`=1, `valid_out`=0, `rd_data_out`=0x00, `rx_error_out`=0. Both FIFOs are empty, both FSMs are in IDLE, and the synchroniser flops are 1.
- **Reset mid-frame:** `tx_out` returns to 1 immediately (asynchronously). A partial RX frame is discarded.
- **TX latency:** a write accepted at edge k with TX idle and the FIFO empty is popped at edge k+1, and `tx_out` falls at edge k+1.
- **TX bit timing:** each bit is held exactly `CLKS_PER_BIT` cycles. A frame lasts 10×`CLKS_PER_BIT` cycles (11× with parity).
- **Status flags:** `ready_out` and `valid_out` are registered from FIFO occupancy and update the cycle after the push or pop.
- **RX latency:** `valid_out` rises 1 cycle after the stop-bit sample edge. That sample is 2 sync cycles plus 9.5 bit periods after the falling edge on `rx_in` (10.5 with parity).

## Configuration
- `SERIAL_PORT_PARITY_EN`
  - **Defined:** 8E1 framing. TX inserts an even-parity bit after D7. RX checks it; on mismatch the byte is dropped and `rx_error_out` is set.
  - **Undefined:** 8N1 framing. The PARITY states are absent from both FSMs.

## Structure
- **Package `serial_pkg`:**
  - `DATA_BITS`=8.
  - Default `CLKS_PER_BIT`.
  - Enum typedefs for the TX and RX FSM states.
  - Frame constants `START_BIT`=0 and `STOP_BIT`=1.
- **Sub-module `serial_fifo`:**
  - Parameterised on width and depth; first-word-fall-through.
  - Outputs registered `full` and `empty` flags.
  - Read and write pointers each carry one extra wrap bit.
  - Instantiated twice, for TX and RX.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- **Reset:** assert `reset`=0 mid-TX-frame → `tx_out`=1 immediately; all outputs take their reset values. After release the line stays idle.
- **Single TX:** write 0xA5 → `tx_out` falls at the next edge, then carries 1,0,1,0,0,1,0,1 (4 cycles each), then stop=1. The frame is 40 cycles total.
- **TX backpressure:** write 0x00–0x09 on 10 consecutive cycles → `ready_out`=0 after the 9th write and the 10th byte is dropped. The line carries 0x00–0x08 back-to-back with no idle gaps.
- **RX and pop:** drive frame 0x3C on `rx_in` → `valid_out`=1 and `rd_data_out`=0x3C. Pulse `rden_in` → `valid_out`=0 the next cycle.
- **RX overrun:** send 9 frames 0x01–0x09 with no `rden_in` → 8 bytes (0x01–0x08) are buffered and `rx_error_out`=1. Reading back yields 0x01–0x08 only.
- **RX line errors:**
  - A 1-cycle low glitch on `rx_in` → no byte and no error.
  - A frame with stop bit 0 → no byte and `rx_error_out`=1.
  - With `SERIAL_PORT_PARITY_EN` defined, a frame carrying a wrong parity bit → dropped and `rx_error_out`=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants and FSM state types for the serial port block.
// Build option: define SERIAL_PORT_PARITY_EN for 8E1 framing (8N1 otherwise).
package serial_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef SERIAL_PORT_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef SERIAL_PORT_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

`ifdef SERIAL_PORT_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/serial_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
  logic [WIDTH-1:0] last_head;
  logic             do_push, do_pop;

  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  // Next pointer values, used for both the pointer update and the flag registers.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (do_push) wr_ptr_nxt = wr_ptr + PTR_ONE;
    if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
  end

  // Pointer and occupancy-flag registers.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  // Storage write.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; the pointers and empty flag gate every read.
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Remember the head while non-empty so the output holds its last value once drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      last_head <= '0;
    else if (!empty) last_head <= mem[rd_ptr[AW-1:0]];
  end

  assign rd_data = empty ? last_head : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/serial_port.sv
// UART-side serial port: TX FIFO + serialiser, RX synchroniser + deserialiser + RX FIFO.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1).
// Build option: define SERIAL_PORT_PARITY_EN for 8E1 framing (8N1 otherwise).
module serial_port
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] wr_data_in,
  input  logic                 wren_in,
  input  logic                 rden_in,
  output logic [DATA_BITS-1:0] rd_data_out,
  output logic                 valid_out,
  output logic                 ready_out,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic                 rx_error_out
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] BIT_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  // ---------------------------------------------------------------- TX path
  tx_state_t            tx_state;
  logic [TW-1:0]        tx_timer;
  logic [IW-1:0]        tx_bit_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_line;
  logic                 tx_full, tx_empty;
  logic                 tx_push, tx_pop, tx_tick;
`ifdef SERIAL_PORT_PARITY_EN
  logic                 tx_par;
`endif

  assign ready_out = !tx_full;
  assign tx_push   = wren_in && ready_out;
  assign tx_tick   = (tx_timer == BIT_LAST);
  // Load a new byte from idle, or straight from the end of a stop bit (no idle gap).
  assign tx_pop    = !tx_empty &&
                     ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_tick));

  serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (tx_push),
    .wr_data (wr_data_in),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // TX bit timer: held at zero while idle, wraps at the end of every bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              tx_timer <= '0;
    else if ((tx_state == TX_IDLE) || tx_tick) tx_timer <= '0;
    else                                     tx_timer <= tx_timer + TIMER_ONE;
  end

  // TX FSM; the line is registered so it changes exactly on bit boundaries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state   <= TX_IDLE;
      tx_line    <= STOP_BIT;
      tx_shift   <= '0;
      tx_bit_idx <= '0;
`ifdef SERIAL_PORT_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_line  <= START_BIT;
      tx_shift <= tx_head;
`ifdef SERIAL_PORT_PARITY_EN
      tx_par   <= even_parity(tx_head);
`endif
    end else begin
      case (tx_state)
        TX_IDLE: ;
        TX_START: if (tx_tick) begin
          tx_state   <= TX_DATA;
          tx_bit_idx <= '0;
          tx_line    <= tx_shift[0];
        end
        TX_DATA: if (tx_tick) begin
          if (tx_bit_idx == IDX_LAST) begin
`ifdef SERIAL_PORT_PARITY_EN
            tx_state <= TX_PARITY;
            tx_line  <= tx_par;
`else
            tx_state <= TX_STOP;
            tx_line  <= STOP_BIT;
`endif
          end else begin
            tx_bit_idx <= tx_bit_idx + IDX_ONE;
            tx_shift   <= tx_shift >> 1;
            tx_line    <= tx_shift[1];
          end
        end
`ifdef SERIAL_PORT_PARITY_EN
        TX_PARITY: if (tx_tick) begin
          tx_state <= TX_STOP;
          tx_line  <= STOP_BIT;
        end
`endif
        TX_STOP: if (tx_tick) tx_state <= TX_IDLE;
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= STOP_BIT;
        end
      endcase
    end
  end

  assign tx_out = tx_line;

  // ---------------------------------------------------------------- RX path
  rx_state_t            rx_state;
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_prev, rx_fall;
  logic [TW-1:0]        rx_timer;
  logic [IW-1:0]        rx_bit_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_full, rx_empty;
  logic                 rx_tick, rx_half;
  logic                 rx_stop_eval, rx_frame_ok;
  logic                 rx_push, rx_pop, rx_overrun;
  logic                 rx_error;
`ifdef SERIAL_PORT_PARITY_EN
  logic                 rx_par_ok;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};
      rx_prev <= rx_s;
    end
  end

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev && !rx_s;
  assign rx_tick = (rx_timer == BIT_LAST);
  assign rx_half = (rx_timer == BIT_HALF);

`ifdef SERIAL_PORT_PARITY_EN
  assign rx_frame_ok = (rx_s == STOP_BIT) && rx_par_ok;
`else
  assign rx_frame_ok = (rx_s == STOP_BIT);
`endif

  assign rx_stop_eval = (rx_state == RX_STOP) && rx_tick;
  assign rx_push      = rx_stop_eval && rx_frame_ok;
  assign rx_pop       = rden_in && valid_out;
  assign rx_overrun   = rx_push && rx_full && !rx_pop;
  assign valid_out    = !rx_empty;

  serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (rx_push),
    .wr_data (rx_shift),
    .rd_en   (rx_pop),
    .rd_data (rd_data_out),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // RX bit timer: half a bit to the start-bit centre, then full bits from there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        rx_timer <= '0;
    else if (rx_state == RX_IDLE)                      rx_timer <= '0;
    else if ((rx_state == RX_START) ? rx_half : rx_tick) rx_timer <= '0;
    else                                               rx_timer <= rx_timer + TIMER_ONE;
  end

  // RX FSM: sample each bit at its centre and shift in LSB first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
`ifdef SERIAL_PORT_PARITY_EN
      rx_par_ok  <= 1'b0;
`endif
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_fall) rx_state <= RX_START;
        RX_START: if (rx_half) begin
          if (rx_s == START_BIT) begin
            rx_state   <= RX_DATA;
            rx_bit_idx <= '0;
          end else begin
            rx_state <= RX_IDLE;  // false start: glitch shorter than half a bit
          end
        end
        RX_DATA: if (rx_tick) begin
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit_idx == IDX_LAST) begin
`ifdef SERIAL_PORT_PARITY_EN
            rx_state <= RX_PARITY;
`else
            rx_state <= RX_STOP;
`endif
          end else begin
            rx_bit_idx <= rx_bit_idx + IDX_ONE;
          end
        end
`ifdef SERIAL_PORT_PARITY_EN
        RX_PARITY: if (rx_tick) begin
          rx_par_ok <= (rx_s == even_parity(rx_shift));
          rx_state  <= RX_STOP;
        end
`endif
        RX_STOP: if (rx_tick) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky error: framing or parity failure at the stop sample, or overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                       rx_error <= 1'b0;
    else if ((rx_stop_eval && !rx_frame_ok) || rx_overrun) rx_error <= 1'b1;
  end

  assign rx_error_out = rx_error;

endmodule

// File: tb/tb_serial_port.sv
// Directed self-checking bench for serial_port with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef SERIAL_PORT_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] wr_data_in = 8'h00;
  logic       wren_in = 1'b0;
  logic       rden_in = 1'b0;
  logic       rx_in   = 1'b1;
  logic [7:0] rd_data_out;
  logic       valid_out, ready_out, tx_out, rx_error_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_data_in   (wr_data_in),
    .wren_in      (wren_in),
    .rden_in      (rden_in),
    .rd_data_out  (rd_data_out),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .tx_out       (tx_out),
    .rx_in        (rx_in),
    .rx_error_out (rx_error_out)
  );

  // Line bits of one frame, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop_v,
                                             input logic par_flip);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (FB == 11) f[9] = (^b) ^ par_flip;
    f[FB-1] = stop_v;
    return f;
  endfunction

  // Check tx_out every cycle of one frame, starting on its first start-bit cycle.
  task automatic tx_expect_frame(input logic [7:0] b, input string tag);
    logic [10:0] f;
    f = frame_bits(b, 1'b1, 1'b0);
    for (int c = 0; c < FB * CPB; c++) begin
      checks++;
      if (tx_out !== f[c / CPB]) begin
        errors++;
        $display("FAIL %s byte=%h cycle=%0d: tx_out=%b expected %b", tag, b, c, tx_out, f[c / CPB]);
      end
      @(negedge clock);
    end
  endtask

  task automatic tx_expect_idle(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      checks++;
      if (tx_out !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle=%0d: tx_out=%b expected 1", tag, c, tx_out);
      end
      @(negedge clock);
    end
  endtask

  // Drive one frame on rx_in followed by one idle bit time.
  task automatic send_rx(input logic [7:0] b, input logic stop_v, input logic par_flip);
    logic [10:0] f;
    f = frame_bits(b, stop_v, par_flip);
    for (int i = 0; i < FB; i++) begin
      rx_in = f[i];
      repeat (CPB) @(negedge clock);
    end
    rx_in = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b expected 1", tx_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (rd_data_out !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data_out); end
    checks++; if (rx_error_out !== 1'b0) begin errors++; $display("FAIL reset_rx_error: got %b expected 0", rx_error_out); end
    reset = 1'b1;
    @(negedge clock);
    tx_expect_idle(8, "reset_idle");
  endtask

  task automatic test_single_tx();
    wr_data_in = 8'hA5;
    wren_in    = 1'b1;
    @(negedge clock);            // write accepted at this edge
    wren_in = 1'b0;
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL single_tx_pre: tx_out=%b expected 1", tx_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL single_tx_ready: got %b expected 1", ready_out); end
    @(negedge clock);            // popped, line falls
    tx_expect_frame(8'hA5, "single_tx");
    tx_expect_idle(8, "single_tx_idle");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wr_data_in = 8'(i);
          wren_in    = 1'b1;
          @(negedge clock);
          if (i == 7) begin
            checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_after8: got %b expected 1", ready_out); end
          end
          if (i >= 8) begin
            checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_full w%0d: got %b expected 0", i + 1, ready_out); end
          end
        end
        wren_in = 1'b0;
      end
      begin
        repeat (2) @(negedge clock);
        for (int i = 0; i < 9; i++) tx_expect_frame(8'(i), "bp_frame");
      end
    join
    tx_expect_idle(2 * FB * CPB, "bp_idle");
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_drained: got %b expected 1", ready_out); end
  endtask

  task automatic test_rx_pop();
    send_rx(8'h3C, 1'b1, 1'b0);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rx_valid: got %b expected 1", valid_out); end
    checks++; if (rd_data_out !== 8'h3C) begin errors++; $display("FAIL rx_data: got %h expected 3c", rd_data_out); end
    checks++; if (rx_error_out !== 1'b0) begin errors++; $display("FAIL rx_no_error: got %b expected 0", rx_error_out); end
    rden_in = 1'b1;
    @(negedge clock);
    rden_in = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rx_pop_valid: got %b expected 0", valid_out); end
    checks++; if (rd_data_out !== 8'h3C) begin errors++; $display("FAIL rx_pop_hold: got %h expected 3c", rd_data_out); end
    rden_in = 1'b1;              // pop on empty is ignored
    @(negedge clock);
    rden_in = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rx_pop_empty: got %b expected 0", valid_out); end
  endtask

  task automatic test_rx_overrun();
    for (int i = 1; i <= 8; i++) send_rx(8'(i), 1'b1, 1'b0);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", valid_out); end
    checks++; if (rx_error_out !== 1'b0) begin errors++; $display("FAIL ovr_err_before: got %b expected 0", rx_error_out); end
    send_rx(8'h09, 1'b1, 1'b0);
    checks++; if (rx_error_out !== 1'b1) begin errors++; $display("FAIL ovr_err_after: got %b expected 1", rx_error_out); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL ovr_read_valid %0d: got %b expected 1", i, valid_out); end
      checks++; if (rd_data_out !== 8'(i)) begin errors++; $display("FAIL ovr_read_data %0d: got %h expected %h", i, rd_data_out, 8'(i)); end
      rden_in = 1'b1;
      @(negedge clock);
      rden_in = 1'b0;
    end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %b expected 0", valid_out); end
    checks++; if (rd_data_out !== 8'h08) begin errors++; $display("FAIL ovr_hold: got %h expected 08", rd_data_out); end
  endtask

  task automatic test_reset_mid_frame();
    send_rx(8'h5A, 1'b1, 1'b0);
    checks++; if (rd_data_out !== 8'h5A) begin errors++; $display("FAIL rst_pre_rx: got %h expected 5a", rd_data_out); end
    wr_data_in = 8'h00;
    wren_in    = 1'b1;
    @(negedge clock);
    wren_in = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: tx_out=%b expected 0", tx_out); end
    #2 reset = 1'b0;
    #1;
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL rst_async_tx_out: got %b expected 1", tx_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", ready_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", valid_out); end
    checks++; if (rd_data_out !== 8'h00) begin errors++; $display("FAIL rst_async_rd_data: got %h expected 00", rd_data_out); end
    checks++; if (rx_error_out !== 1'b0) begin errors++; $display("FAIL rst_async_rx_error: got %b expected 0", rx_error_out); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tx_expect_idle(2 * FB * CPB, "rst_idle");
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_after: got %b expected 0", valid_out); end
  endtask

  task automatic test_rx_errors();
    rx_in = 1'b0;                // one-cycle glitch
    @(negedge clock);
    rx_in = 1'b1;
    repeat (3 * FB * CPB) @(negedge clock);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", valid_out); end
    checks++; if (rx_error_out !== 1'b0) begin errors++; $display("FAIL glitch_error: got %b expected 0", rx_error_out); end
    send_rx(8'h55, 1'b0, 1'b0);  // stop bit low
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL framing_valid: got %b expected 0", valid_out); end
    checks++; if (rx_error_out !== 1'b1) begin errors++; $display("FAIL framing_error: got %b expected 1", rx_error_out); end
    send_rx(8'h81, 1'b1, 1'b0);  // receiver recovers after the bad frame
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL recover_valid: got %b expected 1", valid_out); end
    checks++; if (rd_data_out !== 8'h81) begin errors++; $display("FAIL recover_data: got %h expected 81", rd_data_out); end
    checks++; if (rx_error_out !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b expected 1", rx_error_out); end
`ifdef SERIAL_PORT_PARITY_EN
    do_reset();
    checks++; if (rx_error_out !== 1'b0) begin errors++; $display("FAIL parity_pre: got %b expected 0", rx_error_out); end
    send_rx(8'hC3, 1'b1, 1'b1);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL parity_valid: got %b expected 0", valid_out); end
    checks++; if (rx_error_out !== 1'b1) begin errors++; $display("FAIL parity_error: got %b expected 1", rx_error_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_back_to_back();
    test_rx_pop();
    test_rx_overrun();
    test_reset_mid_frame();
    test_rx_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
